// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: word type, reset vector, NOP encoding and fetch FSM states.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC = 32'h0000_0000;
  localparam word_t NOP      = 32'h0000_0013;
  localparam word_t PC_STEP  = 32'h0000_0004;

  typedef enum logic {
    REQ   = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  // Force an address onto a word boundary.
  function automatic word_t align_word(input word_t addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter with its next-pc mux; priority is reset, branch, sequential advance, hold.
module fetch_pc
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  branch_taken,
  input  word_t branch_target,
  input  logic  advance,
  output word_t pc,
  output word_t pc_next_c
);

  always_comb begin
    pc_next_c = pc;
    if (rst) begin
      pc_next_c = RESET_PC;
    end else if (branch_taken) begin
      pc_next_c = align_word(branch_target);
    end else if (advance) begin
      pc_next_c = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next_c;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: requests a word, presents it to decode,
// and squashes in-flight data when a branch redirects the stream.
module instruction_fetch
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  output logic  mem_req,
  output word_t mem_addr,
  input  logic  mem_ack,
  input  word_t mem_rdata,
  input  logic  stall,
  input  logic  branch_taken,
  input  word_t branch_target,
  output word_t instr,
  output word_t instr_pc,
  output logic  instr_valid
);

  fetch_state_e state, state_next;
  logic         squash, squash_next;
  logic         accept;
  logic         addr_hold;
  word_t        pc, pc_next;

  fetch_pc u_fetch_pc (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .advance       (accept),
    .pc            (pc),
    .pc_next_c     (pc_next)
  );

  // Next-state logic; a redirect while a request is in flight marks its data for discard.
  always_comb begin
    state_next  = state;
    squash_next = squash;
    accept      = 1'b0;
    addr_hold   = 1'b0;
    case (state)
      REQ: begin
        if (mem_ack) begin
          squash_next = 1'b0;
          if (!squash && !branch_taken) begin
            accept     = 1'b1;
            state_next = ISSUE;
          end
        end else begin
          addr_hold = 1'b1;
          if (branch_taken) begin
            squash_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (branch_taken || !stall) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = REQ;
      end
    endcase
  end

  // mem_addr only moves once the outstanding request has been acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      squash      <= 1'b0;
      mem_req     <= 1'b1;
      mem_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= '0;
    end else begin
      state       <= state_next;
      squash      <= squash_next;
      mem_req     <= (state_next == REQ);
      instr_valid <= (state_next == ISSUE);
      if (!addr_hold) begin
        mem_addr <= pc_next;
      end
      if (accept) begin
        instr    <= mem_rdata;
        instr_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a scoreboard of expected issued instructions.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic prev_valid = 1'b0;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

  instruction_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'h1000_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard whenever a new instruction becomes valid.
  task automatic monitor();
    exp_t e;
    if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_valid observed instr=%h pc=%h expected none", instr, instr_pc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_instr", instr, e.word);
        chk("sb_instr_pc", instr_pc, e.pc);
      end
    end
    prev_valid = instr_valid;
  endtask

  // One clock: drive at negedge, observe at the following negedge.
  task automatic tick(input logic ack, input logic [31:0] rdata, input logic stl,
                      input logic br, input logic [31:0] tgt, input logic r);
    mem_ack       = ack;
    mem_rdata     = rdata;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    rst           = r;
    @(posedge clk);
    @(negedge clk);
    mem_ack      = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    rst          = 1'b0;
    monitor();
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic exp_req(input string tag, input logic [31:0] addr);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_mem_addr"}, mem_addr, addr);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic exp_issue(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr);
    exp_req(tag, addr);
    q.push_back('{word: dat(addr), pc: addr});
    tick(1'b1, dat(addr), 1'b0, 1'b0, 32'h0, 1'b0);
    exp_issue(tag);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    @(posedge clk);
    @(negedge clk);
    exp_req("reset", 32'h0);
    chk("reset_instr", instr, NOP_WORD);
    chk("reset_instr_pc", instr_pc, 32'h0);
    rst = 1'b0;

    // Back-to-back fetches, one instruction every two cycles.
    fetch("seq0", 32'h0);
    idle();
    fetch("seq4", 32'h4);

    // Decode stall holds the presented instruction.
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_issue("stall");
      chk("stall_instr", instr, dat(32'h4));
      chk("stall_instr_pc", instr_pc, 32'h4);
    end
    idle();

    // Slow memory: address held across wait cycles.
    for (int i = 0; i < 3; i++) begin
      exp_req("wait8", 32'h8);
      idle();
    end
    fetch("seq8", 32'h8);
    idle();

    // Branch while a request is outstanding: late data is discarded.
    exp_req("pre_sq", 32'hC);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h103, 1'b0);
    exp_req("sq_hold1", 32'hC);
    idle();
    exp_req("sq_hold2", 32'hC);
    tick(1'b1, JUNK, 1'b0, 1'b0, 32'h0, 1'b0);
    exp_req("sq_target", 32'h100);

    // Two redirects during one squash; only the newest target survives.
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0);
    exp_req("sq2_hold", 32'h100);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
    exp_req("sq2_hold2", 32'h100);
    tick(1'b1, JUNK, 1'b0, 1'b0, 32'h0, 1'b0);
    exp_req("sq2_target", 32'h300);
    fetch("f300", 32'h300);

    // Branch beats stall in ISSUE.
    tick(1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 1'b0);
    exp_req("br_stall", 32'h400);

    // Branch and ack in the same cycle.
    tick(1'b1, JUNK, 1'b0, 1'b1, 32'h500, 1'b0);
    exp_req("br_ack", 32'h500);
    fetch("f500", 32'h500);

    // Ack while presenting is ignored.
    tick(1'b1, JUNK, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_issue("stray_ack");
    chk("stray_ack_instr", instr, dat(32'h500));
    idle();
    exp_req("after_stray", 32'h504);

    // PC wraps past the top of the address space.
    tick(1'b1, JUNK, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    fetch("ftop", 32'hFFFF_FFFC);
    idle();
    exp_req("wrap", 32'h0);

    // Reset abandons an outstanding request.
    tick(1'b1, JUNK, 1'b0, 1'b1, 32'h20, 1'b0);
    exp_req("wait20", 32'h20);
    idle();
    exp_req("wait20b", 32'h20);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    exp_req("rst_mid", 32'h0);
    chk("rst_mid_instr", instr, NOP_WORD);
    chk("rst_mid_instr_pc", instr_pc, 32'h0);
    fetch("post_rst", 32'h0);
    idle();
    exp_req("post_rst_next", 32'h4);

    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
